l80_uart_rx: RTL
================

# l80_uart_rx

Serial receiver for the l80 8080 SoC: consumes the asynchronous `rxd` pin, recovers 8N1 frames with 16x oversampling and 3-sample majority voting, and presents received bytes to the CPU I/O port decoder through a ready/read-strobe interface. It sits between the `rxd` pad and the SoC's I/O read mux, alongside the transmitter that drives `txd`. It also reports framing and overrun errors.

## Interface

- `CLK_HZ`, 12000000, system clock frequency in Hz.
- `BAUD`, 9600, line rate in bit/s.
- `DIV`, derived as CLK_HZ/(BAUD*16), truncated. The default value is 78; a value below 2 is a configuration error.

- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  serial line, idle high, asynchronous to `clock`.
- `rd`  in  1  one-cycle pulse from the CPU that consumes the current byte.
- `rx_data`  out  8  current received byte.
- `rx_ready`  out  1  a byte is available on `rx_data`.
- `frame_err`  out  1  sticky; the stop bit was sampled low.
- `overrun`  out  1  sticky; a byte was dropped because storage was full.
- `err_clr`  in  1  one-cycle pulse that clears `frame_err` and `overrun`.

## Operation

- **Input synchronizer.** `rxd` passes through a 2-flop synchronizer; its output is `rxs`. The synchronizer flops reset to 1.
- **Prescaler.** The prescaler counts 0..DIV-1. It is cleared on start detection and emits `tick` each time it wraps, so the first tick occurs DIV cycles after the clear. A 4-bit `tick_cnt` counts ticks within each bit, and a 4-bit bit index counts bits.
- **Bit numbering.** Bit b is numbered 0 for start, 1–8 for data (LSB first), and 9 for stop. Each bit is sampled on ticks 16b+7, 16b+8 and 16b+9, and the majority value is decided on tick 16b+9.
- **State machine:**
  - IDLE: when `rxs`=0, clear the prescaler and counters and go to START.
  - START: if the majority is 1 (false start or glitch), go to IDLE with no flags set. Otherwise go to DATA.
  - DATA: shift the majority value into the shift register MSB-first so that LSB-first order results. After bit 8, go to STOP.
  - STOP: if the majority is 1, write the byte to storage and go to IDLE. If the majority is 0, set `frame_err`, discard the byte and go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. This prevents a held-low line from retriggering.
- **Storage (default build).** Storage is a single holding register.
  - A write loads `rx_data` and sets `rx_ready`.
  - A write while `rx_ready`=1 with no `rd` in the same cycle drops the new byte, keeps the old byte and sets `overrun`.
  - `rd` with `rx_ready`=1 clears `rx_ready`.
  - `rd` and a write in the same cycle: the new byte is loaded, `rx_ready` stays 1 and no overrun occurs.
  - `rd` while `rx_ready`=0 is ignored.
- **Error flags.** `err_clr` clears both flags. If an error event coincides with `err_clr`, the flag is set; set wins.
- **Reset values.** `rx_data`=8'h00, `rx_ready`=0, `frame_err`=0, `overrun`=0, state IDLE.
- **Reset mid-frame.** The partial frame is discarded. After reset release the block resumes in IDLE; if `rxd` is still low, a new START begins.

## Timing

- Let S be the cycle in which IDLE sees `rxs`=0; this is 2 cycles after `rxd` falls.
- Tick n occurs at S+DIV·n.
- The stop decision is at tick 153: S+11934 with the default parameters.
- `rx_ready` and `rx_data` update 1 cycle later, at S+11935. Flag updates have the same 1-cycle latency after the decision.
- After a good stop, IDLE can detect the next start from the following cycle. Back-to-back frames at the nominal rate are therefore received without loss.
- `rd` takes effect on the next edge: `rx_ready` falls 1 cycle after `rd`.
- Tolerated rate error is about ±3% (sample centre at 8/16 of the bit with 78 vs 78.125 divider truncation).

## Configuration

- `L80_UART_RX_FIFO_EN`
  - **Undefined:** storage is the single holding register described above.
  - **Defined:** storage is a 4-entry show-ahead FIFO with 2-bit pointers that wrap and a 3-bit count.
    - `rx_data` is the head entry.
    - `rx_ready` = (count≠0).
    - `rd` pops the head.
    - A write when count=4 with no simultaneous `rd` drops the byte and sets `overrun`.
    - A simultaneous `rd` and write when full succeed with no overrun.
    - A simultaneous `rd` and write when empty means the write lands and the `rd` is ignored.
    - Reset empties the FIFO.

## Test plan

- **Basic receive.** Idle high for 90 cycles, then send 0x36 at 1250 cycles/bit → `rx_ready`=1 with `rx_data`=8'h36 about 11935 cycles after the falling edge, and no flags. `rd` → `rx_ready`=0.
- **Glitch rejection.** `rxd` low for 300 cycles, then high → no `rx_ready`, no flags, state back in IDLE.
- **Framing error.** Send 0x55 with stop bit 0, held 0 for 3000 cycles → `frame_err`=1 and `rx_ready`=0. After `rxd` returns high, 0xA3 is received correctly. `err_clr` → `frame_err`=0.
- **Overrun.**
  - Default build: send 0x11 then 0x22 with no `rd` → `rx_data`=0x11, `overrun`=1.
  - FIFO build: send 0x01..0x05 with no `rd` → four `rd`s return 0x01..0x04, then `rx_ready`=0 and `overrun`=1.
- **Read/write collision.** With a byte pending (FIFO full in the FIFO build), issue `rd` in the exact write cycle of the next byte → no overrun, and the new byte is readable afterwards.
- **Reset mid-frame.** Pulse `reset_n` low during data bit 4 → all outputs reset. The following complete frame 0x7E is received correctly.

Source files
------------

// File: rtl/l80_uart_rx.sv
// l80_uart_rx: 8N1 serial receiver, 16x oversampling with 3-sample majority vote per bit.
// Define L80_UART_RX_FIFO_EN to replace the single holding register with a 4-entry FIFO.
module l80_uart_rx #(
    parameter int unsigned CLK_HZ = 12000000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr
);
    // DIV below 2 is not a supported configuration
    localparam int unsigned DIV = CLK_HZ / (BAUD * 16);
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic          sync1_q, rxs_q;
    logic [2:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tick_cnt_q, tick_cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [1:0]    samp_q, samp_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_ready_q, rx_ready_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          tick_c, decide_c, maj_c, wr_c, fe_c, ov_c;

    // Bit timing, majority vote and frame sequencing
    always_comb begin
        tick_c     = (presc_q == PW'(DIV - 1));
        decide_c   = tick_c && (tick_cnt_q == 4'd8);
        maj_c      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
        state_d    = state_q;
        presc_d    = tick_c ? '0 : presc_q + PW'(1);
        tick_cnt_d = tick_c ? tick_cnt_q + 4'd1 : tick_cnt_q;
        bit_d      = (tick_c && (tick_cnt_q == 4'd15)) ? bit_q + 4'd1 : bit_q;
        samp_d     = (tick_c && ((tick_cnt_q == 4'd6) || (tick_cnt_q == 4'd7)))
                     ? {samp_q[0], rxs_q} : samp_q;
        shift_d    = shift_q;
        wr_c       = 1'b0;
        fe_c       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxs_q) begin
                    state_d    = ST_START;
                    presc_d    = '0;
                    tick_cnt_d = 4'd0;
                    bit_d      = 4'd0;
                end
            end
            ST_START: begin
                if (decide_c) state_d = maj_c ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (decide_c) begin
                    shift_d = {maj_c, shift_q[7:1]};
                    if (bit_q == 4'd8) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide_c) begin
                    if (maj_c) begin
                        wr_c    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        fe_c    = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef L80_UART_RX_FIFO_EN
    logic [3:0][7:0] mem_q, mem_d;
    logic [1:0]      wp_q, wp_d, rp_q, rp_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            pop_c, push_c;

    // Show-ahead FIFO; a pop frees the slot for a same-cycle push when full
    always_comb begin
        pop_c      = rd && (cnt_q != 3'd0);
        push_c     = wr_c && ((cnt_q != 3'd4) || pop_c);
        ov_c       = wr_c && !push_c;
        mem_d      = mem_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        if (push_c) begin
            mem_d[wp_q] = shift_q;
            wp_d        = wp_q + 2'd1;
        end
        if (pop_c) rp_d = rp_q + 2'd1;
        cnt_d      = cnt_q + 3'(push_c) - 3'(pop_c);
        rx_data_d  = mem_d[rp_d];
        rx_ready_d = (cnt_d != 3'd0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '0;
            wp_q  <= 2'd0;
            rp_q  <= 2'd0;
            cnt_q <= 3'd0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
`else
    // Single holding register; a same-cycle read makes room for the new byte
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_ready_d = rx_ready_q;
        ov_c       = 1'b0;
        if (wr_c) begin
            if (rx_ready_q && !rd) begin
                ov_c = 1'b1;
            end else begin
                rx_data_d  = shift_q;
                rx_ready_d = 1'b1;
            end
        end else if (rd) begin
            rx_ready_d = 1'b0;
        end
    end
`endif

    // Sticky error flags; a set in the same cycle as a clear wins
    always_comb begin
        frame_err_d = fe_c | (frame_err_q & ~err_clr);
        overrun_d   = ov_c | (overrun_q & ~err_clr);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            tick_cnt_q  <= 4'd0;
            bit_q       <= 4'd0;
            samp_q      <= 2'b11;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rxd;
            rxs_q       <= sync1_q;
            state_q     <= state_d;
            presc_q     <= presc_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_q       <= bit_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_ready_q  <= rx_ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_ready  = rx_ready_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule
